// File: rtl/framestore_ram_controller.sv
// Memory-side responder: derives the system clock enables from a 16 MHz phase counter and
// time-shares one synchronous 32 KB RAM between the CRTC video fetch and the CPU.
module framestore_ram_controller (
  input  logic        PIXELCLK,
  input  logic        nRESET,
  output logic        dRAM_en,
  output logic        RAM_en,
  output logic        PROC_en,
  output logic        hPROC_en,
  output logic        PHI_2,
  input  logic [13:0] FRAMESTORE_ADR,
  input  logic [4:0]  ROW_ADDRESS,
  input  logic [1:0]  SCREEN_SIZE,
  output logic [7:0]  vDATABUS,
  input  logic        CPU_SEL,
  input  logic        CPU_RnW,
  input  logic [14:0] CPU_ADR,
  input  logic [7:0]  CPU_DIN,
  output logic [7:0]  CPU_DOUT,
  output logic        RAM_CE,
  output logic        RAM_WE,
  output logic [14:0] RAM_ADDR,
  output logic [7:0]  RAM_WDATA,
  input  logic [7:0]  RAM_RDATA
);

  logic [3:0]  phase;
  logic [2:0]  k;
  logic        cpu_rd_pend;
  logic [14:0] lin;
  logic [14:0] ofs;
  logic [14:0] vid_addr;
  logic        unused_row;

  assign k          = phase[2:0];
  assign unused_row = ^ROW_ADDRESS[4:3];

  assign dRAM_en  = nRESET & phase[0];
  assign RAM_en   = nRESET & (&phase[1:0]);
  assign PROC_en  = nRESET & (&phase[2:0]);
  assign hPROC_en = nRESET & (&phase[3:0]);
  assign PHI_2    = nRESET & phase[2];

  // Hardware wrap: addresses past the top of RAM fold back by the screen size.
  always_comb begin
    lin = {FRAMESTORE_ADR[11:0], ROW_ADDRESS[2:0]};
    case (SCREEN_SIZE)
      2'b00:   ofs = 15'h3000;
      2'b01:   ofs = 15'h4000;
      2'b10:   ofs = 15'h5800;
      default: ofs = 15'h6000;
    endcase
    if (FRAMESTORE_ADR[13])
      vid_addr = {5'b11111, FRAMESTORE_ADR[9:0]};
    else if (FRAMESTORE_ADR[12])
      vid_addr = lin + ofs;
    else
      vid_addr = lin;
  end

  // RAM strobes are registered: loading at the end of k-1 drives the slot during k.
  always_ff @(posedge PIXELCLK) begin
    if (!nRESET) begin
      phase       <= 4'd0;
      vDATABUS    <= 8'h00;
      CPU_DOUT    <= 8'h00;
      RAM_CE      <= 1'b0;
      RAM_WE      <= 1'b0;
      RAM_ADDR    <= 15'h0000;
      RAM_WDATA   <= 8'h00;
      cpu_rd_pend <= 1'b0;
    end else begin
      phase  <= phase + 4'd1;
      RAM_CE <= 1'b0;
      RAM_WE <= 1'b0;
      case (k)
        3'd3: begin
          RAM_CE   <= 1'b1;
          RAM_ADDR <= vid_addr;
        end
        3'd4: begin
          cpu_rd_pend <= CPU_SEL & CPU_RnW;
          if (CPU_SEL) begin
            RAM_CE   <= 1'b1;
            RAM_WE   <= ~CPU_RnW;
            RAM_ADDR <= CPU_ADR;
            if (!CPU_RnW) RAM_WDATA <= CPU_DIN;
          end
        end
        3'd5: vDATABUS <= RAM_RDATA;
        3'd6: begin
          if (cpu_rd_pend) CPU_DOUT <= RAM_RDATA;
          cpu_rd_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
